// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and data (DM) requesters.
// Optional `MEM_ARB_PERF_CNT_EN adds per-requester stall-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_dm_wait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       win_if;
    logic       win_dm;

    // DM has priority unless fetch has been passed over STARVE_MAX times.
    always_comb begin
        win_if = 1'b0;
        win_dm = 1'b0;
        if (reset && state == IDLE) begin
            if (if_req && dm_req) begin
                if (starve_cnt == STARVE_LIM) win_if = 1'b1;
                else                          win_dm = 1'b1;
            end else if (if_req) begin
                win_if = 1'b1;
            end else if (dm_req) begin
                win_dm = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_if)      state_nxt = BUSY_IF;
                else if (win_dm) state_nxt = BUSY_DM;
            end
            BUSY_IF: if (mem_rvalid) state_nxt = IDLE;
            BUSY_DM: if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (win_if) begin
            starve_cnt <= 4'd0;
        end else if (win_dm && if_req && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_comb begin
        if_gnt    = win_if;
        dm_gnt    = win_dm;
        mem_req   = win_if | win_dm;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win_dm) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (win_if) begin
            mem_addr  = if_addr;
        end
        if_rvalid = reset && state == BUSY_IF && mem_rvalid;
        dm_rvalid = reset && state == BUSY_DM && mem_rvalid;
        if_rdata  = reset ? mem_rdata[31:0] : 32'd0;
        dm_rdata  = reset ? mem_rdata : '0;
        stall_if  = reset & if_req & ~if_rvalid;
        stall_mem = reset & dm_req & ~dm_rvalid;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_if_wait <= 32'd0;
            perf_dm_wait <= 32'd0;
        end else begin
            perf_if_wait <= perf_if_wait + {31'd0, stall_if};
            perf_dm_wait <= perf_dm_wait + {31'd0, stall_mem};
        end
    end
`else
    assign perf_if_wait = 32'd0;
    assign perf_dm_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory model.
// Expected commands and responses are queued by stimulus, checked by a monitor.
module tb_mem_port_arbiter;

    typedef struct {
        logic        dm;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [63:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic [31:0] perf_if_wait;
    logic [31:0] perf_dm_wait;

    int          errors = 0;
    int          checks = 0;
    int          lat = 2;
    cmd_t        cmd_q[$];
    logic [31:0] if_q[$];
    logic [63:0] dm_q[$];
    logic [63:0] ram[logic [63:0]];

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: one command at a time, answers after lat cycles.
    initial begin
        logic [63:0] a;
        logic [63:0] rd;
        int          l;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                a = mem_addr;
                l = lat;
                if (mem_we) begin
                    ram[a] = mem_wdata;
                    rd = 64'd0;
                end else begin
                    rd = ram.exists(a) ? ram[a] : 64'd0;
                end
                repeat (l) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
    end

    // Monitor: compares every command and response against the queues.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_mem_req", {63'd0, mem_req}, 64'd0);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_dm_gnt", {63'd0, dm_gnt}, {63'd0, c.dm});
                    chk("cmd_if_gnt", {63'd0, if_gnt}, {63'd0, ~c.dm});
                    chk("cmd_we", {63'd0, mem_we}, {63'd0, c.we});
                    chk("cmd_addr", mem_addr, c.addr);
                    chk("cmd_wdata", mem_wdata, c.wdata);
                end
            end else if (if_gnt || dm_gnt) begin
                chk("gnt_without_mem_req", {63'd0, mem_req}, 64'd1);
            end
            if (if_rvalid) begin
                if (if_q.size() == 0)
                    chk("unexpected_if_rvalid", {63'd0, if_rvalid}, 64'd0);
                else
                    chk("if_rdata", {32'd0, if_rdata}, {32'd0, if_q.pop_front()});
            end
            if (dm_rvalid) begin
                if (dm_q.size() == 0)
                    chk("unexpected_dm_rvalid", {63'd0, dm_rvalid}, 64'd0);
                else
                    chk("dm_rdata", dm_rdata, dm_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic if_access(input logic [63:0] a, input logic [31:0] exp);
        int n = 0;
        bit done = 0;
        if_q.push_back(exp);
        if_addr = a;
        if_req  = 1'b1;
        while (!done && n < 60) begin
            @(negedge clk);
            if (if_rvalid) done = 1;
            n++;
        end
        if (!done) chk("if_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [63:0] a,
                             input logic [63:0] wd, input logic [63:0] exp);
        int n = 0;
        bit done = 0;
        dm_q.push_back(exp);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        while (!done && n < 60) begin
            @(negedge clk);
            if (dm_rvalid) done = 1;
            n++;
        end
        if (!done) chk("dm_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
    endtask

    task automatic push_cmd(input logic dm, input logic we,
                            input logic [63:0] a, input logic [63:0] wd);
        cmd_t c;
        c.dm = dm; c.we = we; c.addr = a; c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_gnt"}, {63'd0, if_gnt}, 64'd0);
        chk({tag, "_dm_gnt"}, {63'd0, dm_gnt}, 64'd0);
        chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
        chk({tag, "_dm_rdata"}, dm_rdata, 64'd0);
        chk({tag, "_stall_if"}, {63'd0, stall_if}, 64'd0);
        chk({tag, "_stall_mem"}, {63'd0, stall_mem}, 64'd0);
        chk({tag, "_rvalid"}, {62'd0, if_rvalid, dm_rvalid}, 64'd0);
    endtask

    initial begin
        logic [31:0] exp_if_perf;
        logic [31:0] exp_dm_perf;
        ram[64'h100] = 64'h1111_2222_0050_0093;
        ram[64'h104] = 64'h0000_0000_0010_0113;
        ram[64'h200] = 64'h1122_3344_5566_7788;
        ram[64'h210] = 64'hCAFE_F00D_0000_0210;
        ram[64'h400] = 64'h0000_0000_0040_0413;
        ram[64'h404] = 64'h0000_0000_0040_4493;
        for (int i = 0; i < 5; i++)
            ram[64'h300 + 64'(8 * i)] = 64'hD0D0_0000_0000_0000 | 64'(i);

        // Reset with requests and non-zero inputs present: outputs masked.
        reset = 1'b0;
        if_req = 1'b1; if_addr = 64'h100;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h208;
        dm_wdata = 64'hFFFF_0000_FFFF_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_mem_req", {63'd0, mem_req}, 64'd0);
        @(posedge clk); #1;

        // IF only, latency 2: stall for t0..t1, data at t2.
        lat = 2;
        push_cmd(1'b0, 1'b0, 64'h100, 64'd0);
        fork
            if_access(64'h100, 32'h0050_0093);
            begin
                @(negedge clk);
                chk("ifonly_stall_t0", {63'd0, stall_if}, 64'd1);
                @(negedge clk);
                chk("ifonly_stall_t1", {63'd0, stall_if}, 64'd1);
                chk("ifonly_no_gnt_t1", {63'd0, if_gnt}, 64'd0);
                @(negedge clk);
                chk("ifonly_stall_t2", {63'd0, stall_if}, 64'd0);
                chk("ifonly_rvalid_t2", {63'd0, if_rvalid}, 64'd1);
            end
        join
        @(posedge clk); #1;

        // Simultaneous: DM first, IF at first IDLE cycle after.
        push_cmd(1'b1, 1'b0, 64'h200, 64'd0);
        push_cmd(1'b0, 1'b0, 64'h104, 64'd0);
        fork
            dm_access(1'b0, 64'h200, 64'd0, 64'h1122_3344_5566_7788);
            if_access(64'h104, 32'h0010_0113);
        join
        @(posedge clk); #1;

        // Store, then read it back.
        push_cmd(1'b1, 1'b1, 64'h208, 64'h0000_0000_DEAD_BEEF);
        dm_access(1'b1, 64'h208, 64'h0000_0000_DEAD_BEEF, 64'd0);
        push_cmd(1'b1, 1'b0, 64'h208, 64'd0);
        dm_access(1'b0, 64'h208, 64'd0, 64'h0000_0000_DEAD_BEEF);
        @(posedge clk); #1;

        // Starvation: four DM grants, then IF, then DM, then IF alone.
        lat = 1;
        for (int i = 0; i < 4; i++)
            push_cmd(1'b1, 1'b0, 64'h300 + 64'(8 * i), 64'd0);
        push_cmd(1'b0, 1'b0, 64'h400, 64'd0);
        push_cmd(1'b1, 1'b0, 64'h320, 64'd0);
        push_cmd(1'b0, 1'b0, 64'h404, 64'd0);
        fork
            for (int i = 0; i < 5; i++)
                dm_access(1'b0, 64'h300 + 64'(8 * i), 64'd0,
                          64'hD0D0_0000_0000_0000 | 64'(i));
            begin
                if_access(64'h400, 32'h0040_0413);
                if_access(64'h404, 32'h0040_4493);
            end
        join
        @(posedge clk); #1;

        // Reset during BUSY_DM; completion lands after release.
        lat = 3;
        push_cmd(1'b1, 1'b0, 64'h210, 64'd0);
        dm_we = 1'b0; dm_addr = 64'h210; dm_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        if_req = 1'b1; if_addr = 64'h104;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b1; dm_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_mem_rvalid_seen", {63'd0, mem_rvalid}, 64'd1);
        chk("midrst_dm_rvalid", {63'd0, dm_rvalid}, 64'd0);
        @(posedge clk); #1;
        lat = 2;
        push_cmd(1'b1, 1'b0, 64'h210, 64'd0);
        dm_access(1'b0, 64'h210, 64'd0, 64'hCAFE_F00D_0000_0210);
        @(posedge clk); #1;

        // Perf counters: fresh reset, IF stalls 3 cycles, DM stalls 2.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("perf_if_cleared", {32'd0, perf_if_wait}, 64'd0);
        chk("perf_dm_cleared", {32'd0, perf_dm_wait}, 64'd0);
        @(posedge clk); #1;
        lat = 3;
        push_cmd(1'b0, 1'b0, 64'h100, 64'd0);
        if_access(64'h100, 32'h0050_0093);
        lat = 2;
        push_cmd(1'b1, 1'b0, 64'h200, 64'd0);
        dm_access(1'b0, 64'h200, 64'd0, 64'h1122_3344_5566_7788);
        @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
        exp_if_perf = 32'd3;
        exp_dm_perf = 32'd2;
`else
        exp_if_perf = 32'd0;
        exp_dm_perf = 32'd0;
`endif
        chk("perf_if_wait", {32'd0, perf_if_wait}, {32'd0, exp_if_perf});
        chk("perf_dm_wait", {32'd0, perf_dm_wait}, {32'd0, exp_dm_perf});

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("if_q_drained", 64'(if_q.size()), 64'd0);
        chk("dm_q_drained", 64'(dm_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory between two requesters: instruction fetch (IF, read-only) and the data-memory stage (DM, read/write).
- Sits between the pipeline stages and the memory macro, replacing separate instruction and data arrays.
- Drives stall outputs so the pipeline freezes while a stage waits for the shared port.
- Data-side priority, with a starvation guard that guarantees fetch progress.

Parameters:
- ADDR_W, 64, address width, both requesters and memory
- DATA_W, 64, memory data width (DM width; IF uses the low 32 bits)
- STARVE_MAX, 4, number of consecutive DM grants with IF pending after which IF must win; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: IF request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction = mem_rdata[31:0]
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse: DM request accepted
- dm_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
- dm_rdata  out  DATA_W  load data = mem_rdata
- mem_req  out  1  one-cycle memory command strobe
- mem_we  out  1  write enable for the command
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_rvalid  in  1  memory completion pulse, for reads and writes
- mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid
- stall_if  out  1  if_req & ~if_rvalid (combinational)
- stall_mem  out  1  dm_req & ~dm_rvalid (combinational)

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM. Exactly one memory transaction is outstanding at a time.
- IDLE, no request: all strobes stay 0.
- IDLE, request present: choose a winner combinationally. Assert the winner's gnt and mem_req in the same cycle, with mem_we/mem_addr/mem_wdata driven from the winner. Go to BUSY_<winner> next cycle. For an IF winner, mem_we=0 and mem_wdata=0.
- Winner rule:
  - Only one request: that requester wins.
  - Both requesting and starve_cnt < STARVE_MAX: DM wins.
  - Both requesting and starve_cnt == STARVE_MAX: IF wins.
- starve_cnt (4 bits):
  - +1 on each DM grant issued while if_req=1.
  - Cleared on every IF grant.
  - Saturates at STARVE_MAX.
- BUSY_x: ignore new requests and hold all gnt and mem_req at 0. On mem_rvalid, pulse x_rvalid for that cycle with x_rdata = mem_rdata (IF gets the low 32 bits), then go to IDLE.
- Latency:
  - Grant to the next possible grant is memory latency + 1 cycles. No same-cycle regrant on mem_rvalid.
  - Grant is zero-cycle (combinational) from IDLE.
- if_rdata and dm_rdata are combinational pass-throughs, only meaningful while the corresponding rvalid is high.
- mem_rvalid received in IDLE is a protocol error: ignore it and produce no rvalid pulse.
- Reset (reset=0 at a clock edge): state=IDLE, starve_cnt=0.
  - Any in-flight transaction is abandoned. A later mem_rvalid from that transaction lands in IDLE and is ignored.
  - While reset=0, all outputs are 0: gnt, rvalid, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, and stalls masked.
- A requester deasserting req before its gnt is a protocol violation; behaviour is undefined, no recovery required.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_wait [31:0] and perf_dm_wait [31:0]. Each increments on every cycle its stall output is 1, wraps at 2^32, and is cleared by reset.
- Undefined: ports are still present and tied to 0, with no counter flops.

Test Plan:
- IF only, memory latency 2: if_req @t0, addr 0x100 -> if_gnt and mem_req @t0 with mem_we=0; mem_rvalid @t2 with mem_rdata=0x00500093 -> if_rvalid @t2, if_rdata=0x00500093; stall_if=1 for t0..t1.
- Simultaneous requests: if_req and dm_req (load, addr 0x200) @t0 -> dm_gnt @t0; if_gnt at the first IDLE cycle after DM completion; starve_cnt=1, then 0.
- Store: dm_req, dm_we=1, addr 0x208, wdata 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, dm_rvalid on memory ack, if_rvalid stays 0.
- Starvation, STARVE_MAX=4: dm_req and if_req both held continuously -> 4 DM grants, 5th grant goes to IF, then DM resumes.
- Reset mid-op: reset=0 during BUSY_DM, memory completes 1 cycle after reset release -> no dm_rvalid, state IDLE, next request granted normally.
- MEM_ARB_PERF_CNT_EN defined: IF stalled for 3 cycles, DM for 2 -> perf_if_wait=3, perf_dm_wait=2; undefined -> both read 0.
